// File: rtl/alu_seq_slice16_pkg.sv
// alu_seq_slice16_pkg: shared types, sizes and 74181 slice functions for alu_seq_slice16.
//    state_t   : sequencer states IDLE/BUSY/DONE
//    SLICE_W   : width of the reused slice (fixed at 4)
//    NSLICE    : slice passes per operation (operand width SLICE_W*NSLICE = 16)
//    alu_pq    : returns {P, Q} addends of the active-high 74181 arithmetic table
//    alu_logic : returns the active-high 74181 logic result
package alu_seq_pkg;
   localparam int SLICE_W = 4;
   localparam int NSLICE  = 4;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   function automatic logic [7:0] alu_pq(input logic [3:0] s, input logic [3:0] a4, input logic [3:0] b4);
      logic [3:0] p, q;
      p = a4 | (b4 & {4{s[0]}}) | (~b4 & {4{s[1]}});
      q = (a4 & ~b4 & {4{s[2]}}) | (a4 & b4 & {4{s[3]}});
      return {p, q};
   endfunction
   // The 74181 logic table is exactly the complement of P xor Q.
   function automatic logic [3:0] alu_logic(input logic [3:0] s, input logic [3:0] a4, input logic [3:0] b4);
      logic [7:0] pq;
      pq = alu_pq(s, a4, b4);
      return ~(pq[7:4] ^ pq[3:0]);
   endfunction
endpackage

// File: rtl/alu_seq_slice16_if.sv
// alu_seq_slice16_if: request/response bundle for alu_seq_slice16.
//    request  : in_valid, in_ready, a, b, cin, s, m
//    response : out_valid, out_ready, f, cout, aeqb (+ ovf when ALU_SEQ_OVF_EN is defined)
//    master drives requests and consumes results; slave is the ALU.
interface alu_seq_slice16_if;
   logic        in_valid, in_ready, cin, m, out_valid, out_ready, cout, aeqb;
   logic [15:0] a, b, f;
   logic [3:0]  s;
`ifdef ALU_SEQ_OVF_EN
   logic        ovf;
   modport master(output in_valid, a, b, cin, s, m, out_ready, input in_ready, out_valid, f, cout, aeqb, ovf);
   modport slave(input in_valid, a, b, cin, s, m, out_ready, output in_ready, out_valid, f, cout, aeqb, ovf);
`else
   modport master(output in_valid, a, b, cin, s, m, out_ready, input in_ready, out_valid, f, cout, aeqb);
   modport slave(input in_valid, a, b, cin, s, m, out_ready, output in_ready, out_valid, f, cout, aeqb);
`endif
endinterface

// File: rtl/alu_seq_slice16_slice.sv
// alu4_slice: combinational 4-bit 74181-style slice.
//    a4, b4 : operand nibbles      s : function select   m : 1 = logic, 0 = arithmetic
//    ci     : carry in             f4 : result nibble    co : carry out (0 in logic mode)
module alu4_slice
   import alu_seq_pkg::*;
(
   input  logic [3:0] a4,
   input  logic [3:0] b4,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       ci,
   output logic [3:0] f4,
   output logic       co
);
   logic [7:0] pq;
   logic [4:0] sum;
   always_comb begin
      pq  = alu_pq(s, a4, b4);
      sum = {1'b0, pq[7:4]} + {1'b0, pq[3:0]} + {4'b0, ci};
      f4  = m ? alu_logic(s, a4, b4) : sum[3:0];
      co  = m ? 1'b0 : sum[4];
   end
endmodule

// File: rtl/alu_seq_slice16.sv
// alu_seq_slice16: 16-bit 74181-style ALU that reuses one 4-bit slice over four cycles, LS nibble first.
//    clk, rst_n : clock (rising edge) and asynchronous active-low reset
//    bus        : alu_seq_slice16_if.slave (valid/ready request, held-valid response)
//    Optional ALU_SEQ_OVF_EN adds bus.ovf, the signed overflow of arithmetic operations.
module alu_seq_slice16
   import alu_seq_pkg::*;
(
   input logic               clk,
   input logic               rst_n,
   alu_seq_slice16_if.slave  bus
);
   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        carry_q, carry_d, m_q, m_d, out_valid_q, out_valid_d;
   logic        cout_q, cout_d, aeqb_q, aeqb_d;
   logic [15:0] a_q, a_d, b_q, b_d, f_q, f_d;
   logic [3:0]  s_q, s_d, a4, b4, f4;
   logic        co, ovf_d, ovf_q;
   assign a4 = a_q[idx_q*SLICE_W +: SLICE_W];
   assign b4 = b_q[idx_q*SLICE_W +: SLICE_W];
   alu4_slice u_slice (.a4(a4), .b4(b4), .s(s_q), .m(m_q), .ci(carry_q), .f4(f4), .co(co));
`ifdef ALU_SEQ_OVF_EN
   logic [7:0] pq;
   // Carry into the slice MSB is recovered from its sum bit: c3 = f3 ^ p3 ^ q3.
   assign pq    = alu_pq(s_q, a4, b4);
   assign ovf_d = m_q ? 1'b0 : co ^ f4[3] ^ pq[7] ^ pq[3];
   assign bus.ovf = ovf_q;
`else
   assign ovf_d = 1'b0;
`endif
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      s_d         = s_q;
      m_d         = m_q;
      f_d         = f_q;
      cout_d      = cout_q;
      aeqb_d      = aeqb_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: if (bus.in_valid) begin
            a_d     = bus.a;
            b_d     = bus.b;
            s_d     = bus.s;
            m_d     = bus.m;
            carry_d = bus.cin;
            f_d     = '0;
            idx_d   = '0;
            state_d = BUSY;
         end
         BUSY: begin
            f_d[idx_q*SLICE_W +: SLICE_W] = f4;
            carry_d = co;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'(NSLICE - 1)) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               cout_d      = co;
               aeqb_d      = f_d == 16'hFFFF;
            end
         end
         DONE: if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         m_q         <= 1'b0;
         f_q         <= '0;
         cout_q      <= 1'b0;
         aeqb_q      <= 1'b0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         s_q         <= s_d;
         m_q         <= m_d;
         f_q         <= f_d;
         cout_q      <= cout_d;
         aeqb_q      <= aeqb_d;
         out_valid_q <= out_valid_d;
         if (state_q == BUSY && idx_q == 2'(NSLICE - 1)) ovf_q <= ovf_d;
      end
   end
   assign bus.in_ready  = state_q == IDLE;
   assign bus.out_valid = out_valid_q;
   assign bus.f         = f_q;
   assign bus.cout      = cout_q;
   assign bus.aeqb      = aeqb_q;
endmodule
